// File: rtl/imm_encoder_pkg.sv
// Shared RV32I encoding constants: opcodes, shift funct3 codes, immediate limits,
// and a small decoder that picks the packing format for a field bundle.
package instruction_defines;

    localparam logic [6:0] ITYPE    = 7'b0010011;
    localparam logic [6:0] LOADTYPE = 7'b0000011;
    localparam logic [6:0] STYPE    = 7'b0100011;
    localparam logic [6:0] RTYPE    = 7'b0110011;
    localparam logic [6:0] BTYPE    = 7'b1100011;

    localparam logic [2:0] F3_SLLI = 3'b001;
    localparam logic [2:0] F3_SRXI = 3'b101;

    localparam int IMM12_MIN = -2048;
    localparam int IMM12_MAX = 2047;
    localparam int BIMM_MIN  = -4096;
    localparam int BIMM_MAX  = 4094;
    localparam int SHAMT_MAX = 31;

    typedef enum logic [2:0] {
        FMT_I,
        FMT_SHIFT,
        FMT_S,
        FMT_R,
        FMT_B,
        FMT_BAD
    } fmt_e;

    function automatic fmt_e decode_fmt(input logic [6:0] op, input logic [2:0] f3);
        fmt_e f;
        case (op)
            ITYPE:    f = (f3 == F3_SLLI || f3 == F3_SRXI) ? FMT_SHIFT : FMT_I;
            LOADTYPE: f = FMT_I;
            STYPE:    f = FMT_S;
            RTYPE:    f = FMT_R;
            BTYPE:    f = FMT_B;
            default:  f = FMT_BAD;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/imm_encoder_fifo.sv
// Small synchronous FIFO with valid/ready on both sides; the head is shown as
// zero while empty so the consumer never sees stale data.
module sync_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_valid,
    output logic             push_ready,
    input  logic [WIDTH-1:0] push_data,
    output logic             pop_valid,
    input  logic             pop_ready,
    output logic [WIDTH-1:0] pop_data
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;

    // The extra top pointer bit separates a full wrap from an empty queue.
    assign empty      = (wptr == rptr);
    assign full       = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign push_ready = !full;
    assign pop_valid  = !empty;
    assign push       = push_valid && !full;
    assign pop        = pop_ready && !empty;
    assign pop_data   = empty ? '0 : mem[rptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/imm_encoder.sv
// Packs decoded instruction fields into RV32I words, flags out-of-range immediates
// and unknown opcodes, and queues {err, instr} in a small output FIFO.
module imm_encoder
    import instruction_defines::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic [6:0]       funct7,
    input  logic [4:0]       rd,
    input  logic [4:0]       rs1,
    input  logic [4:0]       rs2,
    input  logic [WIDTH-1:0] imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] instr_out,
    output logic             err_out,
    output logic [15:0]      enc_count
);

    logic           alive;
    logic           fifo_ready;
    logic [WIDTH:0] enc_word;
    logic [WIDTH:0] head_word;

    function automatic logic [WIDTH:0] encode(
        input logic [6:0]       op,
        input logic [2:0]       f3,
        input logic [6:0]       f7,
        input logic [4:0]       rdv,
        input logic [4:0]       rs1v,
        input logic [4:0]       rs2v,
        input logic [WIDTH-1:0] im
    );
        logic signed [WIDTH-1:0] s;
        logic [WIDTH-1:0]        instr;
        logic                    err;
        s     = $signed(im);
        instr = '0;
        err   = 1'b0;
        case (decode_fmt(op, f3))
            FMT_I: begin
                instr = {im[11:0], rs1v, f3, rdv, op};
                err   = (s < IMM12_MIN) || (s > IMM12_MAX);
            end
            FMT_SHIFT: begin
                instr = {f7, im[4:0], rs1v, f3, rdv, op};
                err   = (s < 0) || (s > SHAMT_MAX);
            end
            FMT_S: begin
                instr = {im[11:5], rs2v, rs1v, f3, im[4:0], op};
                err   = (s < IMM12_MIN) || (s > IMM12_MAX);
            end
            FMT_R: begin
                instr = {f7, rs2v, rs1v, f3, rdv, op};
            end
            FMT_B: begin
                instr = {im[12], im[10:5], rs2v, rs1v, f3, im[4:1], im[11], op};
                err   = (s < BIMM_MIN) || (s > BIMM_MAX) || im[0];
            end
            default: begin
                instr = '0;
                err   = 1'b1;
            end
        endcase
        return {err, instr};
    endfunction

    // Holds in_ready low through reset and for nothing longer than the first edge after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) alive <= 1'b0;
        else        alive <= 1'b1;
    end

    assign enc_word = encode(opcode, funct3, funct7, rd, rs1, rs2, imm);
    assign in_ready = alive && fifo_ready;

    sync_fifo #(
        .WIDTH(WIDTH + 1),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push_valid(in_valid && alive),
        .push_ready(fifo_ready),
        .push_data (enc_word),
        .pop_valid (out_valid),
        .pop_ready (out_ready),
        .pop_data  (head_word)
    );

    assign {err_out, instr_out} = head_word;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                      enc_count <= '0;
        else if (out_valid && out_ready) enc_count <= enc_count + 16'd1;
    end

endmodule

// File: tb/tb_imm_encoder.sv
// Bench for imm_encoder: directed vector table, handshake corner sequences and a
// randomized run scored against an arithmetic reference encoder.
module tb_imm_encoder;

    typedef struct {
        string       name;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [31:0] expInstr;
        logic        expErr;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [6:0]  opcode = '0;
    logic [2:0]  funct3 = '0;
    logic [6:0]  funct7 = '0;
    logic [4:0]  rd = '0;
    logic [4:0]  rs1 = '0;
    logic [4:0]  rs2 = '0;
    logic [31:0] imm = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] instr_out;
    logic        err_out;
    logic [15:0] enc_count;

    int          total = 0;
    int          bad = 0;
    int          popCount = 0;
    bit          monOn = 1'b0;
    logic [32:0] sbq [$];
    vec_t        vecs [$];

    imm_encoder #(.WIDTH(32), .DEPTH(2)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .opcode   (opcode),
        .funct3   (funct3),
        .funct7   (funct7),
        .rd       (rd),
        .rs1      (rs1),
        .rs2      (rs2),
        .imm      (imm),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .instr_out(instr_out),
        .err_out  (err_out),
        .enc_count(enc_count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input vec_t v, input logic valid);
        in_valid = valid;
        opcode   = v.op;
        funct3   = v.f3;
        funct7   = v.f7;
        rd       = v.rd;
        rs1      = v.rs1;
        rs2      = v.rs2;
        imm      = v.imm;
    endtask

    function automatic vec_t makeVec(input string n, input logic [6:0] op, input logic [2:0] f3,
                                     input logic [6:0] f7, input logic [4:0] rdv, input logic [4:0] rs1v,
                                     input logic [4:0] rs2v, input int immv, input logic [31:0] ei,
                                     input logic ee);
        vec_t v;
        v.name = n; v.op = op; v.f3 = f3; v.f7 = f7; v.rd = rdv; v.rs1 = rs1v; v.rs2 = rs2v;
        v.imm = immv; v.expInstr = ei; v.expErr = ee;
        return v;
    endfunction

    // Reference encoder built from field positions with shifts and masks.
    function automatic logic [32:0] refEncode(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                                              input logic [4:0] rdv, input logic [4:0] rs1v,
                                              input logic [4:0] rs2v, input logic [31:0] u);
        int          v;
        logic [31:0] w;
        logic        e;
        v = $signed(u);
        w = 32'(op) | (32'(f3) << 12) | (32'(rs1v) << 15);
        e = 1'b0;
        if (op == 7'h13 && (f3 == 3'd1 || f3 == 3'd5)) begin
            w = w | (32'(rdv) << 7) | ((u & 32'h1F) << 20) | (32'(f7) << 25);
            e = (v < 0) || (v > 31);
        end else if (op == 7'h13 || op == 7'h03) begin
            w = w | (32'(rdv) << 7) | ((u & 32'hFFF) << 20);
            e = (v < -2048) || (v > 2047);
        end else if (op == 7'h23) begin
            w = w | ((u & 32'h1F) << 7) | (32'(rs2v) << 20) | (((u >> 5) & 32'h7F) << 25);
            e = (v < -2048) || (v > 2047);
        end else if (op == 7'h33) begin
            w = w | (32'(rdv) << 7) | (32'(rs2v) << 20) | (32'(f7) << 25);
        end else if (op == 7'h63) begin
            w = w | (((u >> 11) & 32'h1) << 7) | (((u >> 1) & 32'hF) << 8) | (32'(rs2v) << 20)
                  | (((u >> 5) & 32'h3F) << 25) | (((u >> 12) & 32'h1) << 31);
            e = (v < -4096) || (v > 4094) || (v % 2 != 0);
        end else begin
            w = 32'h0;
            e = 1'b1;
        end
        return {e, w};
    endfunction

    task automatic doReset;
        @(negedge clk);
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    // Scoreboard: occupancy, ordering and contents checked at the falling edge.
    always @(negedge clk) begin
        if (monOn && rst_n) begin
            logic [32:0] exp;
            checkOutput("rand_out_valid", 32'(out_valid), 32'(sbq.size() != 0));
            checkOutput("rand_in_ready", 32'(in_ready), 32'(sbq.size() < 2));
            if (out_valid && out_ready) begin
                popCount++;
                if (sbq.size() == 0) begin
                    checkOutput("rand_unexpected_word", 32'(1), 32'(0));
                end else begin
                    exp = sbq.pop_front();
                    checkOutput("rand_instr", instr_out, exp[31:0]);
                    checkOutput("rand_err", 32'(err_out), 32'(exp[32]));
                end
            end
            if (in_valid && in_ready)
                sbq.push_back(refEncode(opcode, funct3, funct7, rd, rs1, rs2, imm));
        end
    end

    initial begin
        vec_t a, b, c, r;
        logic [32:0] e;

        vecs.push_back(makeVec("addi_m1",   7'h13, 3'd0, 7'h00, 5'd5, 5'd6, 5'd0, -1,    32'hFFF30293, 1'b0));
        vecs.push_back(makeVec("sw",        7'h23, 3'd2, 7'h00, 5'd0, 5'd2, 5'd7, 8,     32'h00712423, 1'b0));
        vecs.push_back(makeVec("beq_m4",    7'h63, 3'd0, 7'h00, 5'd0, 5'd1, 5'd2, -4,    32'hFE208EE3, 1'b0));
        vecs.push_back(makeVec("addi_2048", 7'h13, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 2048,  32'h80000013, 1'b1));
        vecs.push_back(makeVec("addi_m2049",7'h13, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, -2049, 32'h7FF00013, 1'b1));
        vecs.push_back(makeVec("beq_odd",   7'h63, 3'd0, 7'h00, 5'd0, 5'd1, 5'd2, 3,     32'h00208163, 1'b1));
        vecs.push_back(makeVec("sub",       7'h33, 3'd0, 7'h20, 5'd3, 5'd1, 5'd2, 123,   32'h402081B3, 1'b0));
        vecs.push_back(makeVec("slli_5",    7'h13, 3'd1, 7'h00, 5'd1, 5'd2, 5'd0, 5,     32'h00511093, 1'b0));
        vecs.push_back(makeVec("srai_31",   7'h13, 3'd5, 7'h20, 5'd1, 5'd2, 5'd0, 31,    32'h41F15093, 1'b0));
        vecs.push_back(makeVec("slli_32",   7'h13, 3'd1, 7'h00, 5'd1, 5'd2, 5'd0, 32,    32'h00011093, 1'b1));
        vecs.push_back(makeVec("slli_m1",   7'h13, 3'd1, 7'h00, 5'd0, 5'd0, 5'd0, -1,    32'h01F01013, 1'b1));
        vecs.push_back(makeVec("lw_m2048",  7'h03, 3'd2, 7'h00, 5'd5, 5'd6, 5'd0, -2048, 32'h80032283, 1'b0));
        vecs.push_back(makeVec("bad_op",    7'h7F, 3'd0, 7'h00, 5'd1, 5'd2, 5'd3, 4,     32'h00000000, 1'b1));
        vecs.push_back(makeVec("b_4094",    7'h63, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 4094,  32'h7E000FE3, 1'b0));
        vecs.push_back(makeVec("b_m4096",   7'h63, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, -4096, 32'h80000063, 1'b0));
        vecs.push_back(makeVec("b_4096",    7'h63, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 4096,  32'h80000063, 1'b1));
        vecs.push_back(makeVec("s_2047",    7'h23, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 2047,  32'h7E000FA3, 1'b0));

        // Reset state
        #2;
        checkOutput("rst_in_ready", 32'(in_ready), 32'(0));
        checkOutput("rst_out_valid", 32'(out_valid), 32'(0));
        checkOutput("rst_instr", instr_out, 32'h0);
        checkOutput("rst_err", 32'(err_out), 32'(0));
        checkOutput("rst_count", 32'(enc_count), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        step();
        checkOutput("rst_release_in_ready", 32'(in_ready), 32'(1));

        // Directed vectors, one word at a time with the consumer always ready
        out_ready = 1'b1;
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i], 1'b1);
            step();
            in_valid = 1'b0;
            checkOutput({vecs[i].name, "_valid"}, 32'(out_valid), 32'(1));
            checkOutput({vecs[i].name, "_instr"}, instr_out, vecs[i].expInstr);
            checkOutput({vecs[i].name, "_err"}, 32'(err_out), 32'(vecs[i].expErr));
            step();
        end
        checkOutput("vec_count", 32'(enc_count), 32'(vecs.size()));

        // Backpressure: third bundle waits until a slot frees, order preserved
        a = vecs[0]; b = vecs[1]; c = vecs[2];
        doReset();
        applyStimulus(a, 1'b1);
        step();
        checkOutput("bp_first_valid", 32'(out_valid), 32'(1));
        applyStimulus(b, 1'b1);
        step();
        checkOutput("bp_full_in_ready", 32'(in_ready), 32'(0));
        applyStimulus(c, 1'b1);
        step();
        step();
        checkOutput("bp_hold_instr", instr_out, a.expInstr);
        checkOutput("bp_hold_in_ready", 32'(in_ready), 32'(0));
        out_ready = 1'b1;
        step();
        checkOutput("bp_second", instr_out, b.expInstr);
        checkOutput("bp_slot_free", 32'(in_ready), 32'(1));
        step();
        checkOutput("bp_third", instr_out, c.expInstr);
        in_valid = 1'b0;
        step();
        checkOutput("bp_drained", 32'(out_valid), 32'(0));
        checkOutput("bp_count", 32'(enc_count), 32'(3));

        // Back-to-back push/pop at occupancy one
        doReset();
        out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            r = makeVec("b2b", 7'h13, 3'd0, 7'h00, 5'(i), 5'(i + 3), 5'd0, i * 7 - 300, 32'h0, 1'b0);
            applyStimulus(r, 1'b1);
            step();
            e = refEncode(r.op, r.f3, r.f7, r.rd, r.rs1, r.rs2, r.imm);
            checkOutput("b2b_valid", 32'(out_valid), 32'(1));
            checkOutput("b2b_instr", instr_out, e[31:0]);
        end
        in_valid = 1'b0;
        step();
        checkOutput("b2b_empty", 32'(out_valid), 32'(0));
        checkOutput("b2b_count", 32'(enc_count), 32'(100));

        // Randomized traffic against the reference encoder
        doReset();
        sbq.delete();
        popCount = 0;
        monOn = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            case ($urandom_range(0, 5))
                0: r.op = 7'h13;
                1: r.op = 7'h03;
                2: r.op = 7'h23;
                3: r.op = 7'h33;
                4: r.op = 7'h63;
                default: r.op = 7'($urandom);
            endcase
            r.f3 = 3'($urandom); r.f7 = 7'($urandom);
            r.rd = 5'($urandom); r.rs1 = 5'($urandom); r.rs2 = 5'($urandom);
            if ($urandom_range(0, 3) == 0) r.imm = $urandom;
            else r.imm = 32'(int'($urandom_range(0, 10000)) - 5000);
            applyStimulus(r, 1'($urandom_range(0, 1)));
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 10 && sbq.size() != 0; k++) step();
        checkOutput("rand_drain", 32'(sbq.size()), 32'(0));
        monOn = 1'b0;
        checkOutput("rand_count", 32'(enc_count), 32'(popCount[15:0]));

        // Asynchronous reset with the FIFO full
        doReset();
        out_ready = 1'b1;
        applyStimulus(vecs[1], 1'b1);
        step();
        in_valid = 1'b0;
        step();
        out_ready = 1'b0;
        applyStimulus(vecs[3], 1'b1);
        step();
        applyStimulus(vecs[2], 1'b1);
        step();
        in_valid = 1'b0;
        checkOutput("ar_pre_full", 32'(in_ready), 32'(0));
        checkOutput("ar_pre_err", 32'(err_out), 32'(1));
        checkOutput("ar_pre_count", 32'(enc_count), 32'(1));
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("ar_out_valid", 32'(out_valid), 32'(0));
        checkOutput("ar_count", 32'(enc_count), 32'(0));
        checkOutput("ar_instr", instr_out, 32'h0);
        checkOutput("ar_err", 32'(err_out), 32'(0));
        checkOutput("ar_in_ready", 32'(in_ready), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        step();
        checkOutput("ar_release_in_ready", 32'(in_ready), 32'(1));
        checkOutput("ar_release_empty", 32'(out_valid), 32'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
